vga_timing_decoder: RTL and testbench

Sink-side counterpart of the 640x480 VGA timing generator: consumes active-low hsync/vsync, a data-enable and a 3-bit RGB pixel, all synchronous to the pixel clock. It recovers pixel coordinates, measures line and frame geometry, and declares lock once the timing is stable. It sits after any video source or pattern generator in the pixel clock domain and feeds capture, overlay or self-check logic.

---
 rtl/vga_timing_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
//   Sink-side VGA timing recovery. Registers incoming hsync/vsync/activevideo/color_px,
//   recovers the current pixel coordinates, measures line/frame geometry and declares
//   lock once LOCK_FRAMES consecutive frames agree.
//
// Parameters
//   HW          width of horizontal counters and measurements (saturating)
//   VW          width of vertical counters and measurements (saturating)
//   LOCK_FRAMES consecutive matching frames needed for lock (1..7)
//
// Ports
//   clk, rst              pixel clock, synchronous active-high reset
//   hsync, vsync          active-low syncs
//   activevideo, color_px data enable and 3-bit RGB pixel (bit 2 = R, bit 0 = B)
//   px_valid, color_out   registered enable / pixel (pixel zeroed when not valid)
//   x_px, y_px            coordinates of the current visible pixel, 0 when not valid
//   line_start            one-cycle pulse per hsync falling edge
//   frame_start           one-cycle pulse per vsync falling edge
//   h_total, v_total      clocks per line, lines per frame (last measurement)
//   h_active, v_active    visible pixels per line, visible lines per frame
//   locked, lock_lost     lock status and one-cycle pulse on losing lock
//   err_count             (only with VGA_DEC_ERRCNT_EN) saturating error counter
//
// Optional feature macro: VGA_DEC_ERRCNT_EN adds err_count.
module vga_timing_decoder #(
  parameter int unsigned HW          = 11,
  parameter int unsigned VW          = 10,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          activevideo,
  input  logic [2:0]    color_px,
  output logic          px_valid,
  output logic [2:0]    color_out,
  output logic [9:0]    x_px,
  output logic [9:0]    y_px,
  output logic          line_start,
  output logic          frame_start,
  output logic [HW-1:0] h_total,
  output logic [VW-1:0] v_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_active,
  output logic          locked,
  output logic          lock_lost
`ifdef VGA_DEC_ERRCNT_EN
  ,
  output logic [7:0]    err_count
`endif
);

  localparam logic [HW-1:0] HMax      = {HW{1'b1}};
  localparam logic [VW-1:0] VMax      = {VW{1'b1}};
  localparam logic [9:0]    CMax      = 10'h3ff;
  localparam logic [2:0]    LockFrames = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  // Input stage and edge-detect history
  logic       s_hs_q, s_vs_q, s_de_q;
  logic [2:0] s_color_q;
  logic       p_hs_q, p_vs_q, p_de_q;
  logic       armed_q;
  logic       hs_fall, vs_fall, de_fall;

  // Counters
  logic [HW-1:0] hc_q, hc_d, hc_inc, h_total_d;
  logic [VW-1:0] vc_q, vc_d, vc_line, v_total_d;
  logic [HW-1:0] hac_q, hac_d, h_active_d;
  logic [VW-1:0] vac_q, vac_d, vac_line, v_active_d;
  logic [9:0]    xc_q, xc_d, yc_q, yc_d;
  logic          line_err_q, line_err_d, line_err_eval, h_mismatch;
  logic          hc_sat_rise, frame_match;

  // Lock FSM
  state_e     state_q, state_d;
  logic [2:0] mc_q, mc_d, mc_inc;
  logic       lock_lost_d;

  assign hs_fall = p_hs_q & ~s_hs_q;
  assign vs_fall = p_vs_q & ~s_vs_q;
  assign de_fall = p_de_q & ~s_de_q;

  always_comb begin
    hc_inc     = (hc_q == HMax) ? hc_q : hc_q + 1'b1;
    hc_d       = hs_fall ? '0 : hc_inc;
    h_total_d  = hs_fall ? hc_inc : h_total;
    h_mismatch = hs_fall && (hc_inc != h_total);
    // A line closing in the vs_fall cycle still belongs to the frame being judged.
    line_err_eval = line_err_q | h_mismatch;
    line_err_d    = vs_fall ? 1'b0 : line_err_eval;

    vc_line   = (hs_fall && (vc_q != VMax)) ? vc_q + 1'b1 : vc_q;
    vc_d      = vs_fall ? '0 : vc_line;
    v_total_d = vs_fall ? vc_line : v_total;

    hac_d      = de_fall ? '0 : ((s_de_q && (hac_q != HMax)) ? hac_q + 1'b1 : hac_q);
    h_active_d = de_fall ? hac_q : h_active;
    vac_line   = (de_fall && (vac_q != VMax)) ? vac_q + 1'b1 : vac_q;
    vac_d      = vs_fall ? '0 : vac_line;
    v_active_d = vs_fall ? vac_line : v_active;

    xc_d = de_fall ? '0 : ((s_de_q && (xc_q != CMax)) ? xc_q + 1'b1 : xc_q);
    yc_d = vs_fall ? '0 : ((de_fall && (yc_q != CMax)) ? yc_q + 1'b1 : yc_q);

    hc_sat_rise = (hc_q != HMax) && (hc_d == HMax);
    frame_match = !line_err_eval && (v_total_d == v_total) && (hc_q != HMax);
  end

  always_comb begin
    state_d     = state_q;
    mc_d        = mc_q;
    lock_lost_d = 1'b0;
    mc_inc      = mc_q + 3'd1;
    unique case (state_q)
      StSearch: begin
        if (vs_fall) begin
          state_d = StMeasure;
          mc_d    = '0;
        end
      end
      StMeasure: begin
        if (vs_fall) begin
          if (frame_match) begin
            mc_d = mc_inc;
            if (mc_inc >= LockFrames) state_d = StLocked;
          end else begin
            mc_d = '0;
          end
        end
      end
      StLocked: begin
        if ((vs_fall && !frame_match) || hc_sat_rise) begin
          state_d     = StSearch;
          mc_d        = '0;
          lock_lost_d = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

`ifdef VGA_DEC_ERRCNT_EN
  logic       line_err_set;
  logic [8:0] err_sum;
  logic [7:0] err_d;
  always_comb begin
    line_err_set = h_mismatch && !line_err_q && (state_q == StLocked);
    err_sum      = {1'b0, err_count} + {8'd0, line_err_set} + {8'd0, lock_lost_d};
    err_d        = err_sum[8] ? 8'hff : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else     err_count <= err_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // Syncs idle high so a sync already low at release is not an edge.
      s_hs_q      <= 1'b1;
      s_vs_q      <= 1'b1;
      s_de_q      <= 1'b0;
      s_color_q   <= '0;
      p_hs_q      <= 1'b1;
      p_vs_q      <= 1'b1;
      p_de_q      <= 1'b0;
      armed_q     <= 1'b0;
      hc_q        <= '0;
      vc_q        <= '0;
      hac_q       <= '0;
      vac_q       <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      line_err_q  <= 1'b0;
      state_q     <= StSearch;
      mc_q        <= '0;
      px_valid    <= 1'b0;
      color_out   <= '0;
      x_px        <= '0;
      y_px        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      h_active    <= '0;
      v_active    <= '0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      s_hs_q    <= hsync;
      s_vs_q    <= vsync;
      s_de_q    <= activevideo;
      s_color_q <= color_px;
      // First sample after reset seeds the history with the pin itself.
      p_hs_q    <= armed_q ? s_hs_q : hsync;
      p_vs_q    <= armed_q ? s_vs_q : vsync;
      p_de_q    <= armed_q ? s_de_q : activevideo;
      armed_q   <= 1'b1;

      hc_q       <= hc_d;
      vc_q       <= vc_d;
      hac_q      <= hac_d;
      vac_q      <= vac_d;
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      line_err_q <= line_err_d;
      state_q    <= state_d;
      mc_q       <= mc_d;

      px_valid    <= s_de_q;
      color_out   <= s_de_q ? s_color_q : 3'd0;
      x_px        <= s_de_q ? xc_q : 10'd0;
      y_px        <= s_de_q ? yc_q : 10'd0;
      line_start  <= hs_fall;
      frame_start <= vs_fall;
      h_total     <= h_total_d;
      v_total     <= v_total_d;
      h_active    <= h_active_d;
      v_active    <= v_active_d;
      locked      <= (state_d == StLocked);
      lock_lost   <= lock_lost_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Bench for vga_timing_decoder. A compact source (64x24 clocks/lines, 40x16 visible)
// keeps every scenario far below the cycle budget while exercising the same logic.
module tb_vga_timing_decoder;

  localparam int HTot  = 64;
  localparam int HAct  = 40;
  localparam int HsBeg = 44;
  localparam int HsEnd = 52;
  localparam int VTot  = 24;
  localparam int VAct  = 16;
  localparam int VsBeg = 18;
  localparam int VsEnd = 20;
  localparam int Frame = HTot * VTot;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync, vsync, activevideo;
  logic [2:0]  color_px;
  logic        px_valid;
  logic [2:0]  color_out;
  logic [9:0]  x_px, y_px;
  logic        line_start, frame_start;
  logic [10:0] h_total, h_active;
  logic [9:0]  v_total, v_active;
  logic        locked, lock_lost;
`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  vga_timing_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .hsync       (hsync),
    .vsync       (vsync),
    .activevideo (activevideo),
    .color_px    (color_px),
    .px_valid    (px_valid),
    .color_out   (color_out),
    .x_px        (x_px),
    .y_px        (y_px),
    .line_start  (line_start),
    .frame_start (frame_start),
    .h_total     (h_total),
    .v_total     (v_total),
    .h_active    (h_active),
    .v_active    (v_active),
    .locked      (locked),
    .lock_lost   (lock_lost)
`ifdef VGA_DEC_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  // Source model
  int gen_hc = 0;
  int gen_vc = 0;
  bit short_en  = 1'b0;  // line 5 lasts HTot-1 clocks
  bit sync_stop = 1'b0;  // both syncs held high
  bit vs_align  = 1'b0;  // vsync falls together with hsync

  always @(posedge clk) begin
    if (gen_hc >= ((short_en && gen_vc == 5) ? HTot - 2 : HTot - 1)) begin
      gen_hc <= 0;
      gen_vc <= (gen_vc == VTot - 1) ? 0 : gen_vc + 1;
    end else begin
      gen_hc <= gen_hc + 1;
    end
  end

  logic hs_low, vs_low_std, vs_low_aln;
  assign hs_low     = (gen_hc >= HsBeg) && (gen_hc < HsEnd);
  assign vs_low_std = (gen_vc >= VsBeg) && (gen_vc < VsEnd);
  assign vs_low_aln = ((gen_vc == VsBeg) && (gen_hc >= HsBeg)) || (gen_vc == VsBeg + 1) ||
                      ((gen_vc == VsEnd) && (gen_hc < HsBeg));
  assign hsync       = sync_stop ? 1'b1 : !hs_low;
  assign vsync       = sync_stop ? 1'b1 : !(vs_align ? vs_low_aln : vs_low_std);
  assign activevideo = (gen_hc < HAct) && (gen_vc < VAct);
  assign color_px    = gen_hc[2:0];

  // Event bookkeeping (only writer of these variables)
  int cyc = 0, last_ls_cyc = 0, lost_cyc = 0, lost_cnt = 0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (line_start === 1'b1) last_ls_cyc = cyc;
    if (lock_lost === 1'b1) begin
      lost_cyc = cyc;
      lost_cnt = lost_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_frame(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 2 * Frame; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_pos(input int y, input int x);
    bit ok = 1'b0;
    for (int i = 0; i < 2 * Frame; i++) begin
      @(negedge clk);
      if (gen_vc == y && gen_hc == x) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic lock_seq(input string tag);
    wait_frame(tag);
    check({tag, "_vs1_locked"}, locked, 0);
    wait_frame(tag);
    check({tag, "_vs2_locked"}, locked, 0);
    wait_frame(tag);
    check({tag, "_vs3_locked"}, locked, 1);
  endtask

  typedef struct {
    int         y;
    int         x;
    logic       vld;
    int         ex;
    int         ey;
    logic [2:0] col;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ex, ey, scan_err, last_x, last_y, lost0;
    bit prev_v, got_end;

    tbl[0] = '{y: 0,  x: 0,  vld: 1'b1, ex: 0,  ey: 0,  col: 3'd0};
    tbl[1] = '{y: 0,  x: 7,  vld: 1'b1, ex: 7,  ey: 0,  col: 3'd7};
    tbl[2] = '{y: 3,  x: 13, vld: 1'b1, ex: 13, ey: 3,  col: 3'd5};
    tbl[3] = '{y: 7,  x: 50, vld: 1'b0, ex: 0,  ey: 0,  col: 3'd0};
    tbl[4] = '{y: 10, x: 25, vld: 1'b1, ex: 25, ey: 10, col: 3'd1};
    tbl[5] = '{y: 14, x: 40, vld: 1'b0, ex: 0,  ey: 0,  col: 3'd0};
    tbl[6] = '{y: 15, x: 39, vld: 1'b1, ex: 39, ey: 15, col: 3'd7};
    tbl[7] = '{y: 16, x: 0,  vld: 1'b0, ex: 0,  ey: 0,  col: 3'd0};

    // Reset state
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs_zero", |{px_valid, color_out, x_px, y_px, line_start, frame_start,
                                  h_total, v_total, h_active, v_active, locked, lock_lost}, 0);
`ifdef VGA_DEC_ERRCNT_EN
    check("reset_err_count", err_count, 0);
`endif

    // Release just after a vsync fall, with vsync still low
    wait_pos(VsBeg, 10);
    rst = 1'b0;
    lock_seq("lock");
    check("h_total", h_total, HTot);
    check("v_total", v_total, VTot);
    check("h_active", h_active, HAct);
    check("v_active", v_active, VAct);

    // Scoreboard over one full frame
    ex = 0; ey = 0; scan_err = 0; last_x = -1; last_y = -1; prev_v = 1'b0; got_end = 1'b0;
    for (int i = 0; i < 2 * Frame; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        got_end = 1'b1;
        break;
      end
      if (px_valid === 1'b1) begin
        if (x_px != ex[9:0] || y_px != ey[9:0] || color_out != ex[2:0]) scan_err++;
        last_x = int'(x_px);
        last_y = int'(y_px);
        ex++;
      end else begin
        if (x_px != 0 || y_px != 0 || color_out != 0) scan_err++;
        if (prev_v) begin
          ex = 0;
          ey++;
        end
      end
      prev_v = px_valid;
    end
    check("scan_end", got_end, 1);
    check("scan_pixels", scan_err, 0);
    check("scan_lines", ey, VAct);
    check("last_x", last_x, HAct - 1);
    check("last_y", last_y, VAct - 1);

    // Directed pixel positions; outputs appear two clocks after the pins
    for (int i = 0; i < 8; i++) begin
      wait_pos(tbl[i].y, tbl[i].x);
      repeat (2) @(negedge clk);
      check($sformatf("tbl%0d_valid", i), px_valid, tbl[i].vld);
      check($sformatf("tbl%0d_x", i), x_px, tbl[i].ex);
      check($sformatf("tbl%0d_y", i), y_px, tbl[i].ey);
      check($sformatf("tbl%0d_color", i), color_out, tbl[i].col);
    end

    // One short line while locked
    wait_pos(5, 0);
    short_en = 1'b1;
    wait_pos(6, 0);
    short_en = 1'b0;
    wait_frame("short");
    check("short_lock_lost", lock_lost, 1);
    check("short_locked", locked, 0);
    check("short_v_total", v_total, VTot);
`ifdef VGA_DEC_ERRCNT_EN
    check("short_err_count", err_count, 2);
`endif
    @(negedge clk);
    check("short_lost_one_cycle", lock_lost, 0);
    lock_seq("relock");

    // Reset in the middle of a visible line
    wait_pos(5, 20);
    check("pre_rst_x", x_px, 18);
    check("pre_rst_y", y_px, 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs_zero", |{px_valid, color_out, x_px, y_px, line_start, frame_start,
                                   h_total, v_total, h_active, v_active, locked, lock_lost}, 0);
    wait_pos(VsBeg, 10);
    rst = 1'b0;
    lock_seq("rst_relock");

    // Sync loss: hc saturates 2047 clocks after the last hsync edge
    wait_pos(2, 0);
    sync_stop = 1'b1;
    got_end = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (lock_lost === 1'b1) begin
        got_end = 1'b1;
        break;
      end
    end
    #1;
    check("satloss_seen", got_end, 1);
    check("satloss_delay", lost_cyc - last_ls_cyc, 2047);
    check("satloss_locked", locked, 0);
    check("satloss_h_total", h_total, HTot);

    // vsync fall coincident with hsync fall
    @(negedge clk);
    rst = 1'b1;
    sync_stop = 1'b0;
    vs_align = 1'b1;
    repeat (3) @(negedge clk);
    wait_pos(VsBeg, 50);
    rst = 1'b0;
    lock_seq("align");
    check("align_v_total", v_total, VTot);
    #1;
    lost0 = lost_cnt;
    wait_frame("align_hold");
    wait_frame("align_hold");
    check("align_hold_locked", locked, 1);
    check("align_hold_v_total", v_total, VTot);
    #1;
    check("align_no_lost", lost_cnt - lost0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
